data_mem_responder: RTL

// Memory-side responder for the CPU data-memory port. Services load (en_fetch_data) and store
// (en_store_data) requests using the CPU-driven address (alu_result) and store data (Rdata2).

---
 rtl/data_mem_responder_if.sv | 20 ++
 rtl/data_mem_responder.sv | 96 +++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// CPU data-memory port: load/store request from the CPU, response from the memory side.
interface data_mem_responder_if;
  logic        en_fetch_data;
  logic        en_store_data;
  logic [31:0] alu_result;
  logic [31:0] Rdata2;
  logic [31:0] data_m;
  logic        mem_ready;
  logic        mem_err;

  modport master (
    output en_fetch_data, en_store_data, alu_result, Rdata2,
    input  data_m, mem_ready, mem_err
  );

  modport slave (
    input  en_fetch_data, en_store_data, alu_result, Rdata2,
    output data_m, mem_ready, mem_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port: captures a load/store, waits WAIT_STATES
// cycles, then strobes mem_ready for one cycle with registered load data and an error flag.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic             is_load_q, is_store_q, err_q;
  logic [31:0]      data_q;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             req, err_in;
  logic [32:0]      off_in;
  logic [IDX_W-1:0] idx_in, sel_idx;
  logic             sel_err, sel_load;

  // A borrow out of the subtraction lands in bit 32, so one compare covers both range ends.
  assign req    = bus.en_fetch_data | bus.en_store_data;
  assign off_in = {1'b0, bus.alu_result} - {1'b0, BASE_ADDR};
  assign idx_in = IDX_W'(off_in >> 2);
  assign err_in = (bus.alu_result[1:0] != 2'b00) | (off_in >= SPAN) |
                  (bus.en_fetch_data & bus.en_store_data);

  // With no wait states RESP is entered on the capture edge, so the live request feeds the load.
  assign sel_idx  = (state == IDLE) ? idx_in            : idx_q;
  assign sel_err  = (state == IDLE) ? err_in            : err_q;
  assign sel_load = (state == IDLE) ? bus.en_fetch_data : is_load_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (req) begin
        cnt_nxt   = '0;
        state_nxt = (WS == 4'd0) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt_nxt == WS) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req) begin
        idx_q      <= idx_in;
        wdata_q    <= bus.Rdata2;
        is_load_q  <= bus.en_fetch_data;
        is_store_q <= bus.en_store_data;
        err_q      <= err_in;
      end
      if (state_nxt == RESP && sel_load)
        data_q <= sel_err ? 32'h0 : mem[sel_idx];
    end
  end

  // Array is never reset; reset forces IDLE asynchronously, which cancels a pending commit.
  always_ff @(posedge clk) begin
    if (state == RESP && is_store_q && !err_q)
      mem[idx_q] <= wdata_q;
  end

  assign bus.data_m    = data_q;
  assign bus.mem_ready = (state == RESP);
  assign bus.mem_err   = (state == RESP) & err_q;

endmodule
